// File: rtl/counter_pkg.sv
// Shared constants for the counting stages: active-low {g,f,e,d,c,b,a} segment
// patterns for hex digits plus a blank pattern for multi-digit drivers.
package counter_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // All segments off; used by multi-digit drivers for leading-zero blanking.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int WIDTH_MAX = 16;

endpackage

// File: rtl/seg7_hex.sv
// Combinational hex to seven-segment decoder, active-low {g,f,e,d,c,b,a}.
module seg7_hex
  import counter_pkg::*;
(
  input  logic [3:0] iHex,
  output logic [6:0] oSeg
);

  always_comb begin
    oSeg = SEG_BLANK;
    case (iHex)
      4'h0: oSeg = SEG_0;
      4'h1: oSeg = SEG_1;
      4'h2: oSeg = SEG_2;
      4'h3: oSeg = SEG_3;
      4'h4: oSeg = SEG_4;
      4'h5: oSeg = SEG_5;
      4'h6: oSeg = SEG_6;
      4'h7: oSeg = SEG_7;
      4'h8: oSeg = SEG_8;
      4'h9: oSeg = SEG_9;
      4'hA: oSeg = SEG_A;
      4'hB: oSeg = SEG_B;
      4'hC: oSeg = SEG_C;
      4'hD: oSeg = SEG_D;
      4'hE: oSeg = SEG_E;
      default: oSeg = SEG_F;
    endcase
  end

endmodule

// File: rtl/counter_mod_n.sv
// Modulo-N up/down counter with enable, saturating parallel load, cascadable
// terminal count, registered wrap pulse and hex display of the low nibble.
module counter_mod_n
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             iEn,
  input  logic             iUp,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iLoadVal,
  output logic [WIDTH-1:0] oQ,
  output logic             oTC,
  output logic             oWrap,
  output logic [6:0]       oDisplay
);

  generate
    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("counter_mod_n: WIDTH out of range 1..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("counter_mod_n: MODULUS out of range 2..2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  // Compare the load value one bit wider so MODULUS = 2**WIDTH never saturates.
  localparam logic [WIDTH_MAX:0] MOD_EXT = (WIDTH_MAX + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_zero;
  logic [WIDTH-1:0] load_sat;

  assign at_max  = (q_q == MAX_VAL);
  assign at_zero = (q_q == '0);
  assign load_sat = ((WIDTH_MAX + 1)'(iLoadVal) >= MOD_EXT) ? MAX_VAL : iLoadVal;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (iLoad) begin
      q_d = load_sat;
    end else if (iEn) begin
      if (iUp) begin
        if (at_max) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          q_d    = MAX_VAL;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign oQ    = q_q;
  assign oWrap = wrap_q;
  assign oTC   = iEn & ~iLoad & ((iUp & at_max) | (~iUp & at_zero));

  logic [3:0] nibble;

  generate
    if (WIDTH >= 4) begin : g_nib_direct
      assign nibble = q_q[3:0];
    end else begin : g_nib_ext
      assign nibble = {{(4 - WIDTH){1'b0}}, q_q};
    end
  endgenerate

  seg7_hex u_seg (
    .iHex (nibble),
    .oSeg (oDisplay)
  );

endmodule
